// File: rtl/pulse_stretcher_fsm.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretcher_fsm
// Description : Stretches a single-cycle trigger strobe into a level pulse of
//               programmable length, followed by an optional hold-off window.
//               Triggers rejected while busy are counted in a saturating
//               counter. Optional macro PULSE_STRETCHER_RETRIGGER_EN makes
//               triggers during ACTIVE/HOLDOFF restart the pulse instead.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher_fsm #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              trig,
  input  logic [CNT_W-1:0]  len,
  input  logic [CNT_W-1:0]  holdoff,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACTIVE  = 2'b01,
    HOLDOFF = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
  localparam logic [DROP_W-1:0] c_drop_one = DROP_W'(1);
  localparam logic [DROP_W-1:0] c_drop_max = '1;

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [CNT_W-1:0]    r_hcnt, w_hcnt_n;
  logic [CNT_W-1:0]    r_hold, w_hold_n;
  logic                w_done_n;
  logic                w_reject;
  logic [CNT_W-1:0]    w_len_eff;
  logic [DROP_W-1:0]   w_drop_n;

  // A zero length still produces a one-cycle pulse.
  assign w_len_eff = (len == '0) ? c_cnt_one : len;

  // Next-state, counter and strobe logic; outputs follow the next state.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_hcnt_n  = r_hcnt;
    w_hold_n  = r_hold;
    w_done_n  = 1'b0;
    w_reject  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && trig) begin
          w_state_n = ACTIVE;
          w_cnt_n   = w_len_eff - c_cnt_one;
          w_hold_n  = holdoff;
        end
      end
      ACTIVE: begin
        if (!enable) begin
          w_state_n = IDLE;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        else if (trig) begin
          w_cnt_n  = w_len_eff - c_cnt_one;
          w_hold_n = holdoff;
        end
`endif
        else if (r_cnt == '0) begin
          w_done_n = 1'b1;
          if (r_hold == '0) begin
            w_state_n = IDLE;
          end else begin
            w_state_n = HOLDOFF;
            w_hcnt_n  = r_hold - c_cnt_one;
          end
        end else begin
          w_cnt_n = r_cnt - c_cnt_one;
        end
`ifndef PULSE_STRETCHER_RETRIGGER_EN
        w_reject = enable && trig;
`endif
      end
      HOLDOFF: begin
        if (!enable) begin
          w_state_n = IDLE;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        else if (trig) begin
          w_state_n = ACTIVE;
          w_cnt_n   = w_len_eff - c_cnt_one;
          w_hold_n  = holdoff;
        end
`endif
        else if (r_hcnt == '0) begin
          w_state_n = IDLE;
        end else begin
          w_hcnt_n = r_hcnt - c_cnt_one;
        end
`ifndef PULSE_STRETCHER_RETRIGGER_EN
        w_reject = enable && trig;
`endif
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // Saturating count of rejected triggers.
  assign w_drop_n = (w_reject && (drop_cnt != c_drop_max)) ? (drop_cnt + c_drop_one)
                                                           : drop_cnt;

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_hold    <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_hcnt    <= w_hcnt_n;
      r_hold    <= w_hold_n;
      pulse_out <= (w_state_n == ACTIVE);
      busy      <= (w_state_n != IDLE);
      done      <= w_done_n;
      drop_cnt  <= w_drop_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_stretcher_fsm
// Description : Self-checking bench for pulse_stretcher_fsm: a vector table
//               plus hand-written multi-cycle sequences, checked through an
//               expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher_fsm;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        trig;
  logic [15:0] len;
  logic [15:0] holdoff;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic [7:0]  drop_cnt;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        en;
    logic        tr;
    logic [15:0] ln;
    logic [15:0] ho;
    logic [2:0]  flags;   // {pulse_out, busy, done}
    logic [7:0]  drop;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] flags;
    logic [7:0] drop;
  } exp_t;

  vec_t tbl[19];
  exp_t sbq[$];

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam logic [7:0] D_BASE = 8'd0;
`else
  localparam logic [7:0] D_BASE = 8'd2;
`endif

  pulse_stretcher_fsm #(.CNT_W(16), .DROP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .trig      (trig),
    .len       (len),
    .holdoff   (holdoff),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic compare_out();
    exp_t x;
    x = sbq.pop_front();
    n_cmp++;
    if ({pulse_out, busy, done} !== x.flags || drop_cnt !== x.drop) begin
      n_bad++;
      $display("FAIL %s: got p/b/d=%b drop=%0d, required p/b/d=%b drop=%0d",
               x.name, {pulse_out, busy, done}, drop_cnt, x.flags, x.drop);
    end
  endtask

  // Drive one cycle of inputs and check the outputs after the clock edge.
  task automatic step(input string nm, input logic e, input logic t,
                      input logic [15:0] l, input logic [15:0] h,
                      input logic [2:0] f, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    enable  = e;
    trig    = t;
    len     = l;
    holdoff = h;
    x.name = nm; x.flags = f; x.drop = d;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  // Check outputs at the current time without advancing the clock.
  task automatic check_now(input string nm, input logic [2:0] f, input logic [7:0] d);
    exp_t x;
    x.name = nm; x.flags = f; x.drop = d;
    sbq.push_back(x);
    compare_out();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    enable  = 1'b0;
    trig    = 1'b0;
    len     = '0;
    holdoff = '0;

    // Basic stretch len=5, then len=0/holdoff=3, enable=0 trigger, len=1 and back-to-back idle accept.
    tbl[0]  = '{1'b1, 1'b1, 16'd5, 16'd0, 3'b110, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 16'd5, 16'd0, 3'b110, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 16'd5, 16'd0, 3'b110, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 16'd5, 16'd0, 3'b110, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 16'd5, 16'd0, 3'b110, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 16'd5, 16'd0, 3'b001, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 16'd5, 16'd0, 3'b000, 8'd0};
    tbl[7]  = '{1'b1, 1'b1, 16'd0, 16'd3, 3'b110, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 16'd0, 16'd3, 3'b011, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 16'd0, 16'd3, 3'b010, 8'd0};
    tbl[10] = '{1'b1, 1'b0, 16'd0, 16'd3, 3'b010, 8'd0};
    tbl[11] = '{1'b1, 1'b0, 16'd0, 16'd3, 3'b000, 8'd0};
    tbl[12] = '{1'b0, 1'b1, 16'd3, 16'd0, 3'b000, 8'd0};
    tbl[13] = '{1'b1, 1'b1, 16'd1, 16'd0, 3'b110, 8'd0};
    tbl[14] = '{1'b1, 1'b0, 16'd1, 16'd0, 3'b001, 8'd0};
    tbl[15] = '{1'b1, 1'b1, 16'd3, 16'd0, 3'b110, 8'd0};
    tbl[16] = '{1'b1, 1'b0, 16'd3, 16'd0, 3'b110, 8'd0};
    tbl[17] = '{1'b1, 1'b0, 16'd3, 16'd0, 3'b110, 8'd0};
    tbl[18] = '{1'b1, 1'b0, 16'd3, 16'd0, 3'b001, 8'd0};

    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", 3'b000, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), tbl[i].en, tbl[i].tr, tbl[i].ln, tbl[i].ho,
           tbl[i].flags, tbl[i].drop);
    end

    // Enable abort at pulse cycle 3; triggers with enable=0 are not counted.
    step("abort_trig", 1'b1, 1'b1, 16'd8, 16'd0, 3'b110, 8'd0);
    step("abort_c2",   1'b1, 1'b0, 16'd8, 16'd0, 3'b110, 8'd0);
    step("abort_c3",   1'b1, 1'b0, 16'd8, 16'd0, 3'b110, 8'd0);
    step("abort_off",  1'b0, 1'b0, 16'd8, 16'd0, 3'b000, 8'd0);
    for (int i = 0; i < 3; i++)
      step("abort_dis_trig", 1'b0, 1'b1, 16'd8, 16'd0, 3'b000, 8'd0);
    step("abort_idle", 1'b1, 1'b0, 16'd8, 16'd0, 3'b000, 8'd0);

`ifndef PULSE_STRETCHER_RETRIGGER_EN
    // Trigger during hold-off is dropped.
    step("ho_trig",   1'b1, 1'b1, 16'd0, 16'd3, 3'b110, 8'd0);
    step("ho_first",  1'b1, 1'b0, 16'd0, 16'd3, 3'b011, 8'd0);
    step("ho_drop",   1'b1, 1'b1, 16'd0, 16'd3, 3'b010, 8'd1);
    step("ho_last",   1'b1, 1'b0, 16'd0, 16'd3, 3'b010, 8'd1);
    step("ho_idle",   1'b1, 1'b0, 16'd0, 16'd3, 3'b000, 8'd1);
    // Back-to-back: trig in last ACTIVE cycle dropped, first IDLE cycle accepted.
    step("b2b_trig",  1'b1, 1'b1, 16'd2, 16'd0, 3'b110, 8'd1);
    step("b2b_c2",    1'b1, 1'b0, 16'd2, 16'd0, 3'b110, 8'd1);
    step("b2b_drop",  1'b1, 1'b1, 16'd2, 16'd0, 3'b001, 8'd2);
    step("b2b_acc",   1'b1, 1'b1, 16'd2, 16'd0, 3'b110, 8'd2);
    step("b2b_c2b",   1'b1, 1'b0, 16'd2, 16'd0, 3'b110, 8'd2);
    step("b2b_done",  1'b1, 1'b0, 16'd2, 16'd0, 3'b001, 8'd2);
`else
    // Retrigger at cycle 4 extends the pulse to 10 continuous cycles.
    step("rt_trig0",  1'b1, 1'b1, 16'd6, 16'd0, 3'b110, 8'd0);
    for (int i = 0; i < 3; i++)
      step("rt_hi_a", 1'b1, 1'b0, 16'd6, 16'd0, 3'b110, 8'd0);
    step("rt_trig4",  1'b1, 1'b1, 16'd6, 16'd0, 3'b110, 8'd0);
    for (int i = 0; i < 5; i++)
      step("rt_hi_b", 1'b1, 1'b0, 16'd6, 16'd0, 3'b110, 8'd0);
    step("rt_done",   1'b1, 1'b0, 16'd6, 16'd0, 3'b001, 8'd0);
    step("rt_idle",   1'b1, 1'b0, 16'd6, 16'd0, 3'b000, 8'd0);
    // Trigger in hold-off starts a new pulse.
    step("rth_trig",  1'b1, 1'b1, 16'd0, 16'd3, 3'b110, 8'd0);
    step("rth_ho",    1'b1, 1'b0, 16'd0, 16'd3, 3'b011, 8'd0);
    step("rth_new",   1'b1, 1'b1, 16'd2, 16'd0, 3'b110, 8'd0);
    step("rth_c2",    1'b1, 1'b0, 16'd2, 16'd0, 3'b110, 8'd0);
    step("rth_done",  1'b1, 1'b0, 16'd2, 16'd0, 3'b001, 8'd0);
`endif

    // Asynchronous reset mid-pulse clears outputs before the next edge.
    step("rst_trig",  1'b1, 1'b1, 16'd10, 16'd0, 3'b110, D_BASE);
    for (int i = 0; i < 3; i++)
      step("rst_hi",  1'b1, 1'b0, 16'd10, 16'd0, 3'b110, D_BASE);
    #2;
    reset = 1'b1;
    #1;
    check_now("rst_async", 3'b000, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    trig  = 1'b0;

`ifndef PULSE_STRETCHER_RETRIGGER_EN
    // len latched at 4 even though len changes to 9 mid-pulse.
    step("lat_trig",  1'b1, 1'b1, 16'd4, 16'd2, 3'b110, 8'd0);
    step("lat_c2",    1'b1, 1'b1, 16'd9, 16'd2, 3'b110, 8'd1);
    step("lat_c3",    1'b1, 1'b1, 16'd9, 16'd2, 3'b110, 8'd2);
    step("lat_c4",    1'b1, 1'b1, 16'd9, 16'd2, 3'b110, 8'd3);
    step("lat_end",   1'b1, 1'b1, 16'd9, 16'd2, 3'b011, 8'd4);
    // Continuous triggering saturates the drop counter.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      enable = 1'b1; trig = 1'b1; len = 16'd4; holdoff = 16'd2;
    end
    @(negedge clk);
    trig = 1'b0;
    repeat (10) @(negedge clk);
    check_now("sat_final", 3'b000, 8'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
